// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: simple ops, signed Booth multiply, signed restoring divide
// Define ALU_SEQ_RADIX4_EN to use radix-4 Booth multiply (WIDTH/2 iterations).
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_SEQ_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
`else
  localparam int ITERS = WIDTH;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SIMPLE, S_MUL, S_DIV, S_DIVFIX, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         sel_q;
  logic [2*WIDTH:0]   acc_q;   // {partial product high, multiplier/product low, Booth q-1 bit}
  logic [WIDTH-1:0]   quo_q, rem_q;
  logic [CW-1:0]      cnt_q;
  logic               fix_ph_q, dz_q;

  logic [WIDTH-1:0]   z_d;
  logic [2*WIDTH-1:0] dbl;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH:0]   acc_d;
  logic [WIDTH-1:0]   babs, trial;
  logic [WIDTH:0]     rem_sh;
  logic               take;

  always_comb begin
    sh  = b_q[SHW-1:0];
    dbl = {a_q, a_q};
    z_d = '0;
    case (sel_q)
      4'h0: z_d = a_q + b_q;
      4'h1: z_d = a_q - b_q;
      4'h2: z_d = a_q >> sh;
      4'h3: z_d = a_q << sh;
      4'h4: z_d = WIDTH'(dbl >> sh);
      4'h5: z_d = WIDTH'((dbl << sh) >> WIDTH);
      4'h6: z_d = a_q & b_q;
      4'h7: z_d = a_q | b_q;
      4'hA: z_d = '0 - a_q;
      4'hB: z_d = ~a_q;
      default: z_d = '0;
    endcase
  end

`ifdef ALU_SEQ_RADIX4_EN
  logic [WIDTH+1:0] hx4, m1, m2, sum4;
  always_comb begin
    hx4 = {{2{acc_q[2*WIDTH]}}, acc_q[2*WIDTH:WIDTH+1]};
    m1  = {{2{a_q[WIDTH-1]}}, a_q};
    m2  = {m1[WIDTH:0], 1'b0};
    case (acc_q[2:0])
      3'b001, 3'b010: sum4 = hx4 + m1;
      3'b011:         sum4 = hx4 + m2;
      3'b100:         sum4 = hx4 - m2;
      3'b101, 3'b110: sum4 = hx4 - m1;
      default:        sum4 = hx4;
    endcase
    acc_d = {sum4[WIDTH+1:2], sum4[1:0], acc_q[WIDTH:2]};
  end
`else
  logic [WIDTH:0] hx2, m1, sum2;
  always_comb begin
    hx2 = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    m1  = {a_q[WIDTH-1], a_q};
    case (acc_q[1:0])
      2'b01:   sum2 = hx2 + m1;
      2'b10:   sum2 = hx2 - m1;
      default: sum2 = hx2;
    endcase
    acc_d = {sum2[WIDTH:1], sum2[0], acc_q[WIDTH:1]};
  end
`endif

  // Divider works on magnitudes; a remainder below the divisor fits in WIDTH bits after subtraction.
  always_comb begin
    babs   = b_q[WIDTH-1] ? -b_q : b_q;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    take   = (rem_sh >= {1'b0, babs});
    trial  = rem_sh[WIDTH-1:0] - babs;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      fix_ph_q <= 1'b0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      z        <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sel_q    <= select;
            acc_q    <= {{WIDTH{1'b0}}, b, 1'b0};
            quo_q    <= a[WIDTH-1] ? -a : a;
            rem_q    <= '0;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            dz_q     <= (b == '0);
            div_zero <= 1'b0;
            busy     <= 1'b1;
            if (select == 4'h8)      state_q <= S_MUL;
            else if (select == 4'h9) state_q <= (b == '0) ? S_DIVFIX : S_DIV;
            else                     state_q <= S_SIMPLE;
          end
        end
        S_SIMPLE: begin
          z       <= z_d;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_DONE;
        end
        S_MUL: begin
          if (cnt_q == CW'(ITERS)) begin
            hi      <= acc_q[2*WIDTH:WIDTH+1];
            lo      <= acc_q[WIDTH:1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DIV: begin
          quo_q <= {quo_q[WIDTH-2:0], take};
          rem_q <= take ? trial : rem_sh[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_DIVFIX;
        end
        S_DIVFIX: begin
          // First cycle applies the signs, second publishes the results.
          if (!fix_ph_q) begin
            fix_ph_q <= 1'b1;
            if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) quo_q <= -quo_q;
            if (a_q[WIDTH-1])                rem_q <= -rem_q;
          end else begin
            lo       <= dz_q ? '1 : quo_q;
            hi       <= dz_q ? a_q : rem_q;
            div_zero <= dz_q;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a signed-arithmetic model
module tb_alu_seq;
  localparam int W = 32;
`ifdef ALU_SEQ_RADIX4_EN
  localparam int MUL_LAT = W / 2 + 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic clk = 1'b0, clr_n, start;
  logic [3:0] select;
  logic [W-1:0] a, b, z, hi, lo;
  logic busy, done, div_zero;

  int checks = 0, errors = 0;
  logic [W-1:0] exp_z, exp_hi, exp_lo;
  logic exp_dz;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .select(select), .a(a), .b(b),
    .busy(busy), .done(done), .z(z), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  task automatic model_op(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    longint sx, sy, p, q, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = x;
    exp_dz = 1'b0;
    case (s)
      4'h0: exp_z = x + y;
      4'h1: exp_z = x - y;
      4'h2: exp_z = x >> y[4:0];
      4'h3: exp_z = x << y[4:0];
      4'h4: begin repeat (int'(y[4:0])) r = {r[0], r[W-1:1]}; exp_z = r; end
      4'h5: begin repeat (int'(y[4:0])) r = {r[W-2:0], r[W-1]}; exp_z = r; end
      4'h6: exp_z = x & y;
      4'h7: exp_z = x | y;
      4'h8: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'h9: begin
        if (y == 0) begin
          exp_lo = '1; exp_hi = x; exp_dz = 1'b1;
        end else begin
          q = sx / sy; rm = sx % sy;
          exp_lo = q[31:0]; exp_hi = rm[31:0];
        end
      end
      4'hA: exp_z = -x;
      4'hB: exp_z = ~x;
      default: exp_z = '0;
    endcase
  endtask

  function automatic int lat_of(input logic [3:0] s, input logic [W-1:0] y);
    if (s == 4'h8) return MUL_LAT;
    if (s == 4'h9) return (y == 0) ? 2 : W + 2;
    return 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Holds start until accepted, scrambles the inputs, then counts cycles to done.
  task automatic run_op(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int aw);
    select = s; a = x; b = y; start = 1'b1;
    aw = 0;
    do begin @(posedge clk); #1; aw++; end while (!busy && aw < 4);
    start = 1'b0; select = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; select = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || z !== '0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b z=%h hi=%h lo=%h required all zero", busy, done, div_zero, z, hi, lo);
    end
    clr_n = 1'b1;
    exp_z = '0; exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_simple();
    logic [3:0] s; logic [W-1:0] x, y; int lat, aw;
    for (int i = 0; i < 46; i++) begin
      case (i)
        0: begin s = 4'h4; x = 32'h0000_007C; y = 32'h0000_0024; end
        1: begin s = 4'h0; x = 32'h7FFF_FFFF; y = 32'h0000_0001; end
        2: begin s = 4'hA; x = 32'h8000_0000; y = $urandom; end
        3: begin s = 4'h2; x = 32'h1234_5678; y = 32'h0000_0020; end
        4: begin s = 4'hC; x = $urandom; y = $urandom; end
        5: begin s = 4'h5; x = 32'h8000_0001; y = 32'h0000_0001; end
        default: begin
          do s = 4'($urandom_range(0, 15)); while (s == 4'h8 || s == 4'h9);
          x = pick(); y = pick();
        end
      endcase
      run_op(s, x, y, lat, aw);
      model_op(s, x, y);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL simple_lat op=%h got=%0d want=1", s, lat); end
      checks++;
      if (z !== exp_z || hi !== exp_hi || lo !== exp_lo || div_zero !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL simple_res op=%h a=%h b=%h z=%h/%h hi=%h/%h lo=%h/%h dz=%b busy=%b", s, x, y, z, exp_z, hi, exp_hi, lo, exp_lo, div_zero, busy);
      end
      if (i == 0) begin
        checks++;
        if (z !== 32'hC000_0007) begin errors++; $display("FAIL rotate_const got=%h want=C0000007", z); end
      end
      if (i == 1) begin
        checks++;
        if (z !== 32'h8000_0000) begin errors++; $display("FAIL addwrap_const got=%h want=80000000", z); end
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] x, y; int lat, aw;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin x = 32'h0000_0007; y = 32'hFFFF_FFFD; end
        1: begin x = 32'h8000_0000; y = 32'h8000_0000; end
        2: begin x = 32'h8000_0000; y = 32'h0000_0001; end
        3: begin x = 32'hFFFF_FFFF; y = 32'h7FFF_FFFF; end
        default: begin x = pick(); y = pick(); end
      endcase
      run_op(4'h8, x, y, lat, aw);
      model_op(4'h8, x, y);
      checks++;
      if (lat !== MUL_LAT) begin errors++; $display("FAIL mul_lat got=%0d want=%0d", lat, MUL_LAT); end
      checks++;
      if (z !== exp_z || hi !== exp_hi || lo !== exp_lo || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL mul_res a=%h b=%h hi=%h/%h lo=%h/%h z=%h/%h dz=%b", x, y, hi, exp_hi, lo, exp_lo, z, exp_z, div_zero);
      end
      if (i == 0) begin
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_const got=%h%h want=FFFFFFFFFFFFFFEB", hi, lo); end
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] x, y; int lat, aw;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0: begin x = 32'hFFFF_FFF9; y = 32'h0000_0002; end
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'h0000_0005; y = 32'h0000_0000; end
        3: begin x = 32'h0000_0007; y = 32'hFFFF_FFFE; end
        4: begin x = 32'h8000_0000; y = 32'h8000_0000; end
        default: begin x = pick(); y = pick(); end
      endcase
      run_op(4'h9, x, y, lat, aw);
      model_op(4'h9, x, y);
      checks++;
      if (lat !== lat_of(4'h9, y)) begin errors++; $display("FAIL div_lat b=%h got=%0d want=%0d", y, lat, lat_of(4'h9, y)); end
      checks++;
      if (z !== exp_z || hi !== exp_hi || lo !== exp_lo || div_zero !== exp_dz) begin
        errors++;
        $display("FAIL div_res a=%h b=%h hi=%h/%h lo=%h/%h dz=%b/%b z=%h/%h", x, y, hi, exp_hi, lo, exp_lo, div_zero, exp_dz, z, exp_z);
      end
      if (i <= 2) begin
        checks++;
        if ((i == 0 && {lo, hi} !== 64'hFFFF_FFFD_FFFF_FFFF) ||
            (i == 1 && {lo, hi} !== 64'h8000_0000_0000_0000) ||
            (i == 2 && {div_zero, lo, hi} !== {1'b1, 64'hFFFF_FFFF_0000_0005})) begin
          errors++;
          $display("FAIL div_const case=%0d lo=%h hi=%h dz=%b", i, lo, hi, div_zero);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s; logic [W-1:0] x, y; int lat, aw;
    for (int i = 0; i < 8; i++) begin
      s = (i % 3 == 0) ? 4'h9 : ((i % 3 == 1) ? 4'h8 : 4'h1);
      x = pick(); y = pick();
      run_op(s, x, y, lat, aw);
      model_op(s, x, y);
      checks++;
      if (aw > 2 || lat !== lat_of(s, y)) begin
        errors++;
        $display("FAIL b2b_timing op=%h accept_wait=%0d lat=%0d want_lat=%0d", s, aw, lat, lat_of(s, y));
      end
      checks++;
      if (z !== exp_z || hi !== exp_hi || lo !== exp_lo || div_zero !== exp_dz) begin
        errors++;
        $display("FAIL b2b_res op=%h z=%h/%h hi=%h/%h lo=%h/%h", s, z, exp_z, hi, exp_hi, lo, exp_lo);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_ignore_start();
    int lat;
    select = 4'h8; a = 32'h0000_0007; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_op(4'h8, 32'h0000_0007, 32'hFFFF_FFFD);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
      start = (lat == 5 || lat == 6);
      select = 4'h9; a = 32'd100; b = 32'd3;
    end
    start = 1'b0;
    checks++;
    if (lat !== MUL_LAT || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL ignore_start lat=%0d/%0d hi=%h/%h lo=%h/%h", lat, MUL_LAT, hi, exp_hi, lo, exp_lo);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL no_queue busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, aw;
    bit seen;
    run_op(4'hB, 32'h0, 32'h0, lat, aw);
    model_op(4'hB, 32'h0, 32'h0);
    select = 4'h8; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || z !== '0 || hi !== '0 || lo !== '0 || exp_z === '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b z=%h hi=%h lo=%h want all zero", busy, done, z, hi, lo);
    end
    @(posedge clk); #1 clr_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_done saw busy/done after abort=%b want 0", seen); end
    exp_z = '0; exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    run_op(4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, aw);
    model_op(4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checks++;
    if (z !== exp_z || hi !== exp_hi || lo !== exp_lo || lat !== 1) begin
      errors++;
      $display("FAIL post_reset_op z=%h/%h hi=%h lo=%h lat=%0d", z, exp_z, hi, lo, lat);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mul();
    test_div();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
